// File: rtl/ttt_move_driver.sv
// ----------------------------------------------------------------------------
// ttt_move_driver
//
// Move-issuing front end for the TicTacToe game core. Accepts a player move
// over a valid/ready handshake, validates it against the live board, strobes
// the core's `play` input, waits for the board to show the move, picks the
// computer's reply by scanning the board, strobes `pc`, and waits again.
//
// Build option:
//   TTT_SMART_MOVE_EN  when defined, the computer reply is chosen by priority
//                      (win, block, centre, corner, first empty); otherwise
//                      the lowest-index empty cell is chosen.
//
// Parameters:
//   HOLD_CYCLES   cycles each `play` / `pc` strobe is held high
//   ACK_TIMEOUT   cycles to wait for the board to reflect a move
//
// Ports:
//   clock               rising-edge clock
//   reset               synchronous, active-low reset
//   key_valid/key_pos   offered player move (cell 0..8)
//   key_ready           driver can accept a move
//   pos1..pos9          board cells from the core (00 empty, 01 player,
//                       10 computer, 11 reserved)
//   who                 game result from the core (00 = in progress)
//   play/pc             player / computer move strobes to the core
//   player_position     cell presented with `play`
//   computer_position   cell presented with `pc`
//   illegal             one-cycle pulse: offered move rejected
//   ack_err             sticky: board failed to reflect a move in time
//   game_over           high while `who` is non-zero
// ----------------------------------------------------------------------------
module ttt_move_driver #(
   parameter int HOLD_CYCLES = 5,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_pos,
   output logic       key_ready,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic [1:0] who,
   output logic       play,
   output logic       pc,
   output logic [3:0] player_position,
   output logic [3:0] computer_position,
   output logic       illegal,
   output logic       ack_err,
   output logic       game_over
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_PLAY   = 3'd2;
   localparam logic [2:0] S_WAIT_P = 3'd3;
   localparam logic [2:0] S_SEARCH = 3'd4;
   localparam logic [2:0] S_PC     = 3'd5;
   localparam logic [2:0] S_WAIT_C = 3'd6;
   localparam logic [2:0] S_DONE   = 3'd7;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_PLYR  = 2'b01;
   localparam logic [1:0] CELL_COMP  = 2'b10;

   // One counter serves both the strobe hold and the acknowledge timeout.
   localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   // ------------------------------------------------------------------
   // Board view: board[0] is pos1 ... board[8] is pos9
   // ------------------------------------------------------------------
   logic [8:0][1:0] board;
   logic [8:0]      empty_m;
   logic            any_empty;

   assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

   always_comb begin
      empty_m = '0;
      for (int c = 0; c < 9; c++) empty_m[c] = (board[c] == CELL_EMPTY);
   end

   assign any_empty = |empty_m;

   // Out-of-range cells read as reserved so they never look empty or owned.
   function automatic logic [1:0] cell_at(input logic [8:0][1:0] b,
                                          input logic [3:0]      idx);
      logic [1:0] r;
      r = 2'b11;
      if (idx <= 4'd8) r = b[idx];
      return r;
   endfunction

   function automatic logic [3:0] lowest(input logic [8:0] m);
      logic [3:0] r;
      r = 4'd0;
      for (int c = 8; c >= 0; c--) begin
         if (m[c]) r = 4'(c);
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Computer move selection
   // ------------------------------------------------------------------
   logic [3:0] pick;

`ifdef TTT_SMART_MOVE_EN
   localparam logic [8:0] CORNER_M = 9'b1_0100_0101;   // cells 0, 2, 6, 8

   // Lines: rows, columns, then the two diagonals.
   function automatic logic [11:0] line_cells(input logic [2:0] l);
      logic [11:0] r;
      case (l)
         3'd0:    r = {4'd0, 4'd1, 4'd2};
         3'd1:    r = {4'd3, 4'd4, 4'd5};
         3'd2:    r = {4'd6, 4'd7, 4'd8};
         3'd3:    r = {4'd0, 4'd3, 4'd6};
         3'd4:    r = {4'd1, 4'd4, 4'd7};
         3'd5:    r = {4'd2, 4'd5, 4'd8};
         3'd6:    r = {4'd0, 4'd4, 4'd8};
         default: r = {4'd2, 4'd4, 4'd6};
      endcase
      return r;
   endfunction

   logic [8:0]  win_m;
   logic [8:0]  blk_m;
   logic [11:0] ln;
   logic [3:0]  ca, cb, cc;

   // Mark every empty cell that would finish a line; the lowest marked
   // index is taken later, which makes line scan order irrelevant.
   always_comb begin
      win_m = '0;
      blk_m = '0;
      ln    = '0;
      ca    = '0;
      cb    = '0;
      cc    = '0;
      for (int l = 0; l < 8; l++) begin
         ln = line_cells(3'(l));
         ca = ln[11:8];
         cb = ln[7:4];
         cc = ln[3:0];
         if (board[ca] == CELL_EMPTY && board[cb] == CELL_COMP && board[cc] == CELL_COMP) win_m[ca] = 1'b1;
         if (board[cb] == CELL_EMPTY && board[ca] == CELL_COMP && board[cc] == CELL_COMP) win_m[cb] = 1'b1;
         if (board[cc] == CELL_EMPTY && board[ca] == CELL_COMP && board[cb] == CELL_COMP) win_m[cc] = 1'b1;
         if (board[ca] == CELL_EMPTY && board[cb] == CELL_PLYR && board[cc] == CELL_PLYR) blk_m[ca] = 1'b1;
         if (board[cb] == CELL_EMPTY && board[ca] == CELL_PLYR && board[cc] == CELL_PLYR) blk_m[cb] = 1'b1;
         if (board[cc] == CELL_EMPTY && board[ca] == CELL_PLYR && board[cb] == CELL_PLYR) blk_m[cc] = 1'b1;
      end
   end

   always_comb begin
      if (|win_m)                      pick = lowest(win_m);
      else if (|blk_m)                 pick = lowest(blk_m);
      else if (empty_m[4])             pick = 4'd4;
      else if (|(empty_m & CORNER_M))  pick = lowest(empty_m & CORNER_M);
      else                             pick = lowest(empty_m);
   end
`else
   assign pick = lowest(empty_m);
`endif

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   logic [2:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [3:0]       tgt_q,     tgt_d;
   logic [3:0]       ppos_q,    ppos_d;
   logic [3:0]       cpos_q,    cpos_d;
   logic             illegal_q, illegal_d;
   logic             ack_err_q, ack_err_d;

   // Ready is held off during reset and for the cycle the rejection pulse
   // is visible, so a new key is never taken alongside `illegal`.
   assign key_ready = reset && (state_q == S_IDLE) && !illegal_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tgt_d     = tgt_q;
      ppos_d    = ppos_q;
      cpos_d    = cpos_q;
      illegal_d = 1'b0;
      ack_err_d = ack_err_q;
      case (state_q)
         S_IDLE: begin
            if (who != 2'b00) begin
               state_d = S_DONE;
            end else if (key_valid && key_ready) begin
               tgt_d   = key_pos;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (tgt_q > 4'd8 || cell_at(board, tgt_q) != CELL_EMPTY) begin
               illegal_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               ppos_d  = tgt_q;
               cnt_d   = '0;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_P;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_P: begin
            if (cell_at(board, ppos_q) == CELL_PLYR) begin
               state_d = (who != 2'b00 || !any_empty) ? S_DONE : S_SEARCH;
            end else if (cnt_q == ACK_LAST) begin
               ack_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SEARCH: begin
            cpos_d  = pick;
            cnt_d   = '0;
            state_d = S_PC;
         end
         S_PC: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_C;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_C: begin
            if (cell_at(board, cpos_q) == CELL_COMP) begin
               state_d = (who != 2'b00) ? S_DONE : S_IDLE;
            end else if (cnt_q == ACK_LAST) begin
               ack_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tgt_q     <= '0;
         ppos_q    <= '0;
         cpos_q    <= '0;
         illegal_q <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tgt_q     <= tgt_d;
         ppos_q    <= ppos_d;
         cpos_q    <= cpos_d;
         illegal_q <= illegal_d;
         ack_err_q <= ack_err_d;
      end
   end

   // Strobes decode straight from state, so they can never overlap and the
   // WAIT_P + SEARCH cycles always separate `play` from `pc`.
   assign play              = (state_q == S_PLAY);
   assign pc                = (state_q == S_PC);
   assign player_position   = ppos_q;
   assign computer_position = cpos_q;
   assign illegal           = illegal_q;
   assign ack_err           = ack_err_q;
   assign game_over         = (who != 2'b00);

endmodule

// File: tb/tb_ttt_move_driver.sv
module tb_ttt_move_driver;

   localparam int HOLD = 5;
   localparam int ACK  = 16;

   typedef logic [8:0][1:0] board_t;

   logic       clk;
   logic       rst_n;
   logic       kv;
   logic [3:0] kpos;
   logic       key_ready;
   board_t     brd;
   logic [1:0] who_r;
   logic       play, pc, illegal, ack_err, game_over;
   logic [3:0] player_position, computer_position;

   int n_tests = 0;
   int n_fail  = 0;

   ttt_move_driver #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACK)) dut (
      .clock(clk), .reset(rst_n),
      .key_valid(kv), .key_pos(kpos), .key_ready(key_ready),
      .pos1(brd[0]), .pos2(brd[1]), .pos3(brd[2]),
      .pos4(brd[3]), .pos5(brd[4]), .pos6(brd[5]),
      .pos7(brd[6]), .pos8(brd[7]), .pos9(brd[8]),
      .who(who_r),
      .play(play), .pc(pc),
      .player_position(player_position), .computer_position(computer_position),
      .illegal(illegal), .ack_err(ack_err), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // ---------------- reference model: game rules ----------------
   function automatic bit wins(input board_t b, input logic [1:0] p);
      for (int r = 0; r < 3; r++)
         if (b[3*r] == p && b[3*r+1] == p && b[3*r+2] == p) return 1'b1;
      for (int c = 0; c < 3; c++)
         if (b[c] == p && b[c+3] == p && b[c+6] == p) return 1'b1;
      if (b[0] == p && b[4] == p && b[8] == p) return 1'b1;
      if (b[2] == p && b[4] == p && b[6] == p) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit full(input board_t b);
      for (int c = 0; c < 9; c++) if (b[c] == 2'b00) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [1:0] calc_who(input board_t b);
      if (wins(b, 2'b01)) return 2'b01;
      if (wins(b, 2'b10)) return 2'b10;
      if (full(b))        return 2'b11;
      return 2'b00;
   endfunction

   // Reply choice: try each move hypothetically and ask whether it wins.
   function automatic int comp_choice(input board_t b);
      board_t t;
`ifdef TTT_SMART_MOVE_EN
      for (int c = 0; c < 9; c++) if (b[c] == 2'b00) begin
         t = b; t[c] = 2'b10;
         if (wins(t, 2'b10)) return c;
      end
      for (int c = 0; c < 9; c++) if (b[c] == 2'b00) begin
         t = b; t[c] = 2'b01;
         if (wins(t, 2'b01)) return c;
      end
      if (b[4] == 2'b00) return 4;
      if (b[0] == 2'b00) return 0;
      if (b[2] == 2'b00) return 2;
      if (b[6] == 2'b00) return 6;
      if (b[8] == 2'b00) return 8;
`endif
      t = b;
      for (int c = 0; c < 9; c++) if (t[c] == 2'b00) return c;
      return 0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; kv = 1'b0; kpos = '0; brd = '0; who_r = 2'b00;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   // Offer one move and play the core's part of the exchange.
   // dp/dc: cycles before the board shows the player/computer move.
   task automatic do_move(input int kp, input int dp, input int dc, input bit respond);
      bit exp_ill;
      bit bad;
      int n;
      int cp;
      if (kp > 8) exp_ill = 1'b1;
      else        exp_ill = (brd[kp] != 2'b00);
      check("ready_before", key_ready, 1);
      kv = 1'b1; kpos = 4'(kp);
      step();
      kv = 1'b0;
      check("no_play_in_check", play, 0);
      step();
      if (exp_ill) begin
         check("illegal_pulse", illegal, 1);
         check("illegal_ready_low", key_ready, 0);
         check("illegal_no_play", play, 0);
         step();
         check("illegal_one_cycle", illegal, 0);
         check("ready_after_illegal", key_ready, 1);
         return;
      end
      check("play_rise", play, 1);
      check("play_pos", player_position, kp);
      n = 0; bad = 1'b0;
      while (play === 1'b1 && n < 50) begin
         n++;
         if (pc !== 1'b0) bad = 1'b1;
         kv = 1'($urandom_range(0, 1));      // must be ignored outside IDLE
         kpos = 4'($urandom_range(0, 15));
         step();
      end
      kv = 1'b0;
      check("play_len", n, HOLD);
      check("pc_during_play", bad, 0);
      if (!respond) begin
         n = 0;
         while (ack_err !== 1'b1 && n < 40) begin n++; step(); end
         check("ack_timeout_cycles", n, ACK);
         check("ready_after_timeout", key_ready, 1);
         check("no_pc_after_timeout", pc, 0);
         return;
      end
      repeat (dp) step();
      brd[kp] = 2'b01;
      who_r = calc_who(brd);
      step();
      check("no_pc_in_search", pc, 0);
      if (who_r != 2'b00 || full(brd)) begin
         step();
         check("over_no_pc", pc, 0);
         check("over_ready", key_ready, 0);
         check("over_flag", game_over, who_r != 2'b00);
         return;
      end
      cp = comp_choice(brd);
      step();
      check("pc_rise", pc, 1);
      check("pc_pos", computer_position, cp);
      check("play_pos_hold", player_position, kp);
      n = 0; bad = 1'b0;
      while (pc === 1'b1 && n < 50) begin
         n++;
         if (play !== 1'b0) bad = 1'b1;
         step();
      end
      check("pc_len", n, HOLD);
      check("play_during_pc", bad, 0);
      repeat (dc) step();
      brd[cp] = 2'b10;
      who_r = calc_who(brd);
      step();
      check("ready_after_reply", key_ready, who_r == 2'b00);
      check("game_over_after_reply", game_over, who_r != 2'b00);
   endtask

   initial begin
      int kp;
      int tries;
      int empt[$];
      bit bad;
      rst_n = 1'b0; kv = 1'b0; kpos = '0; brd = '0; who_r = 2'b00;

      // Reset
      repeat (10) step();
      check("rst_ready_low", key_ready, 0);
      check("rst_play", play, 0);
      check("rst_pc", pc, 0);
      rst_n = 1'b1;
      step();
      check("post_rst_ready", key_ready, 1);
      check("post_rst_play", play, 0);
      check("post_rst_pc", pc, 0);
      check("post_rst_ppos", player_position, 0);
      check("post_rst_cpos", computer_position, 0);
      check("post_rst_illegal", illegal, 0);
      check("post_rst_ack_err", ack_err, 0);
      check("post_rst_game_over", game_over, 0);

      // Legal move on empty board
      do_move(2, 1, 0, 1'b1);

      // Illegal: occupied cell, then out-of-range cell
      do_reset();
      brd[6] = 2'b10;
      do_move(6, 0, 0, 1'b1);
      do_move(9, 0, 0, 1'b1);

      // Win beats block
      do_reset();
      brd[0] = 2'b10; brd[1] = 2'b10; brd[3] = 2'b01; brd[4] = 2'b01;
      do_move(8, 0, 1, 1'b1);

      // Acknowledge timeout; operation continues afterwards
      do_reset();
      do_move(0, 0, 0, 1'b0);
      do_move(0, 2, 2, 1'b1);
      check("ack_err_sticky", ack_err, 1);

      // Reset in the middle of a strobe
      do_reset();
      kv = 1'b1; kpos = 4'd1;
      step(); kv = 1'b0;
      step(); step();
      check("mid_play_high", play, 1);
      rst_n = 1'b0;
      step();
      check("mid_rst_play_drop", play, 0);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (8) begin step(); if (play !== 1'b0 || pc !== 1'b0) bad = 1'b1; end
      check("no_retry_after_rst", bad, 0);
      check("mid_rst_ready", key_ready, 1);

      // Game over during WAIT_P, keys ignored afterwards
      do_reset();
      brd[0] = 2'b01; brd[1] = 2'b01; brd[3] = 2'b10; brd[4] = 2'b10;
      do_move(2, 2, 0, 1'b1);
      kv = 1'b1; kpos = 4'd5;
      bad = 1'b0;
      repeat (6) begin step(); if (play !== 1'b0 || pc !== 1'b0 || key_ready !== 1'b0) bad = 1'b1; end
      kv = 1'b0;
      check("done_ignores_keys", bad, 0);
      check("done_game_over", game_over, 1);

      // Random games against the model
      for (int g = 0; g < 25; g++) begin
         do_reset();
         tries = 0;
         while (who_r == 2'b00 && !full(brd) && tries < 20) begin
            tries++;
            if ($urandom_range(0, 3) == 0) begin
               kp = $urandom_range(0, 9);
            end else begin
               empt.delete();
               for (int c = 0; c < 9; c++) if (brd[c] == 2'b00) empt.push_back(c);
               kp = empt[$urandom_range(0, empt.size() - 1)];
            end
            do_move(kp, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ttt_move_driver.md
# ttt_move_driver

Move-issuing front end for the TicTacToe game core. It accepts a player move from a keypad-style valid/ready source and validates it against the live board. It then drives the core's `play` and `pc` strobes with `player_position` and `computer_position`, and chooses the computer's reply itself by scanning the board outputs. It sits between the user-input logic and the game core, on the driving side of the core's play/pc interface.

## Interface
Parameters:
- `HOLD_CYCLES`, default 5: cycles each strobe (`play` or `pc`) is held high.
- `ACK_TIMEOUT`, default 16: cycles to wait for the board to reflect a move before flagging an error.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  a player move is offered.
- `key_pos`  in  4  offered cell, 0..8, maps to `pos1`..`pos9`.
- `key_ready`  out  1  driver can accept a move.
- `pos1`..`pos9`  in  2 each  board state from the core: 00 empty, 01 player, 10 computer, 11 reserved.
- `who`  in  2  result from the core: 00 in progress, 01 player won, 10 computer won, 11 draw.
- `play`  out  1  player-move strobe to the core.
- `pc`  out  1  computer-move strobe to the core.
- `player_position`  out  4  cell for `play`.
- `computer_position`  out  4  cell for `pc`.
- `illegal`  out  1  one-cycle pulse: offered move rejected.
- `ack_err`  out  1  sticky: board did not reflect a move within `ACK_TIMEOUT`.
- `game_over`  out  1  high while `who != 00`.

## Operation
States:
- **IDLE**
  - `key_ready` is 1.
  - On `key_valid && key_ready`, capture `key_pos` and go to CHECK.
  - If `who != 00`, go to DONE. This check takes priority over accepting a key.
- **CHECK**
  - If `key_pos > 8` or the target cell is not 00, pulse `illegal` and return to IDLE.
  - Otherwise load `player_position` and go to PLAY.
- **PLAY**
  - `play` = 1 and `pc` = 0 for `HOLD_CYCLES` cycles, then go to WAIT_P.
- **WAIT_P**
  - When the target cell reads 01:
    - go to DONE if `who != 00` or no empty cell remains;
    - otherwise go to SEARCH.
  - After `ACK_TIMEOUT` cycles without that, set `ack_err` and go to IDLE.
- **SEARCH**
  - One cycle; the board is combinationally scanned.
  - Load `computer_position` with the chosen cell, then go to PC.
- **PC**
  - `pc` = 1 and `play` = 0 for `HOLD_CYCLES` cycles, then go to WAIT_C.
- **WAIT_C**
  - Same as WAIT_P, but the expected value is 10.
  - On success, go to IDLE, or to DONE if `who != 00`.
- **DONE**
  - `key_ready` is 0. The block stays here until reset.

General rules:
- `play` and `pc` are never high in the same cycle. There is at least one low cycle between the falling edge of `play` and the rising edge of `pc`.
- `player_position` and `computer_position` are held stable for the entire strobe and until the next load.
- `key_valid` is ignored outside IDLE; no move is queued.
- `ack_err` clears only on reset. Operation continues after it is set.

## Timing
Reset values:
- All outputs are 0 except `key_ready`.
- `key_ready` is 0 during reset and 1 in the first cycle after `reset` deasserts.
- State is IDLE.

Cycle-level behaviour:
- Acceptance edge to `play` high: 2 cycles (CHECK, then PLAY).
- Board acknowledge (cell reads 01) to `pc` high: 2 cycles (WAIT_P exit, then SEARCH).
- `illegal` is asserted in the cycle after CHECK; `key_ready` returns the following cycle.
- Reset mid-strobe: `play` and `pc` drop at the next edge with `reset` low, and no partial move is retried.

## Configuration
- `TTT_SMART_MOVE_EN` defined, SEARCH priority:
  1. a cell that completes a computer line (10,10,00);
  2. a cell that blocks a player line (01,01,00);
  3. centre, cell 4;
  4. lowest-index corner among 0, 2, 6, 8;
  5. lowest-index empty cell.
- Within each priority level, the lowest index wins. The 8 lines are scanned in fixed order: rows, columns, then diagonals 0-4-8 and 2-4-6.
- `TTT_SMART_MOVE_EN` undefined: SEARCH picks the lowest-index empty cell.

## Test plan
- **Reset:** hold `reset`=0 for 10 cycles, then release → `key_ready`=1, `play`=`pc`=0, positions 0.
- **Legal move:** empty board, `key_pos`=2 → `play` high for exactly 5 cycles with `player_position`=2. When the model sets pos3=01, `pc` rises 2 cycles later with `computer_position`=4 when smart, 0 when not.
- **Illegal move:** pos7=10, `key_pos`=6 → `illegal` pulses once and no `play`. Separately, `key_pos`=9 → `illegal`.
- **Smart win/block:** pos1=pos2=10, pos4=pos5=01, `key_pos`=8 → `computer_position`=2, not 5.
- **Timeout:** after `play`, the model never updates the board → `ack_err`=1 after 16 cycles, `key_ready`=1 again.
- **Game over:** `who` goes to 01 during WAIT_P → no `pc` strobe, `game_over`=1, `key_ready`=0 until reset.
